// File: rtl/tue_packet_arbiter.sv
// Round-robin packet arbiter: grant one cycle after a request, locked until the last beat transfers.
// Backpressure: i_ready passes straight through to the owner's ready; all other requesters see 0.
module tue_packet_arbiter #(
    parameter int REQUESTS   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [REQUESTS-1:0]            i_request_valid,
    input  logic [REQUESTS-1:0]            i_request_last,
    input  logic [REQUESTS*DATA_WIDTH-1:0] i_request_data,
    output logic [REQUESTS-1:0]            o_request_ready,
    output logic                           o_valid,
    output logic                           o_last,
    output logic [DATA_WIDTH-1:0]          o_data,
    input  logic                           i_ready,
    output logic [REQUESTS-1:0]            o_grant,
    output logic                           o_busy
);

    localparam int PW = (REQUESTS > 2) ? $clog2(REQUESTS) : 1;
    localparam int IW = PW + 1;

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t                state, state_n;
    logic [REQUESTS-1:0]   grant, grant_n;
    logic [PW-1:0]         owner, owner_n;
    logic [PW-1:0]         ptr, ptr_n;
    logic [PW-1:0]         sel;
    logic [IW-1:0]         idx;
    logic                  found;
    logic                  xfer;

    // First valid requester at or above the pointer, wrapping by subtraction so
    // non-power-of-two requester counts rotate correctly.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < REQUESTS; i++) begin
            idx = {1'b0, ptr} + IW'(i);
            if (idx >= IW'(REQUESTS)) begin
                idx = idx - IW'(REQUESTS);
            end
            if (!found && i_request_valid[idx[PW-1:0]]) begin
                found = 1'b1;
                sel   = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        o_valid = 1'b0;
        o_last  = 1'b0;
        o_data  = '0;
        for (int k = 0; k < REQUESTS; k++) begin
            if (grant[k]) begin
                o_valid = i_request_valid[k];
                o_last  = i_request_last[k];
                o_data  = i_request_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign o_request_ready = grant & {REQUESTS{i_ready}};
    assign o_grant         = grant;
    assign o_busy          = (state == GRANTED);
    assign xfer            = o_valid & i_ready;

    always_comb begin
        state_n = state;
        grant_n = grant;
        owner_n = owner;
        ptr_n   = ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n      = GRANTED;
                    grant_n      = '0;
                    grant_n[sel] = 1'b1;
                    owner_n      = sel;
                end
            end
            GRANTED: begin
                // A valid gap mid-packet keeps the lock; only a completed last beat releases it.
                if (xfer && o_last) begin
                    state_n = IDLE;
                    grant_n = '0;
                    ptr_n   = (owner == PW'(REQUESTS-1)) ? '0 : owner + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            owner <= owner_n;
            ptr   <= ptr_n;
        end
    end

endmodule
